// File: rtl/iob_ethmac_tx_kick.sv
// iob_ethmac_tx_kick: hands one TX frame to the Ethernet MAC through
// its buffer descriptor over IOb, then polls READY until it clears.
module iob_ethmac_tx_kick #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int BD_IDX    = 0,
  parameter int POLL_GAP  = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         frame_ptr,
  input  logic [15:0]         frame_len,
  input  logic                bd_irq,
  input  logic                bd_wrap,
  input  logic                bd_pad,
  input  logic                bd_crc,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                m_valid,
  output logic [ADDR_W-3:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [ADDR_W-3:0] BD_ADDR = (ADDR_W-2)'(256 + 2 * BD_IDX);
  localparam logic [ADDR_W-3:0] PTR_ADDR = (ADDR_W-2)'(257 + 2 * BD_IDX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PTR,
    S_WR_BD,
    S_GAP,
    S_RD_BD,
    S_DONE,
    S_ERR
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_ptr;
  logic [15:0]          r_len;
  logic [3:0]           r_flags;
  logic                 r_valid;
  logic [GAP_W-1:0]     r_gap;
  logic [TIMEOUT_W-1:0] r_tmo;

  logic        w_accept;
  logic        w_xfer;
  logic        w_launch;
  logic        w_tmo_max;
  logic        w_wr_ptr;
  logic        w_wr_bd;
  logic [31:0] w_bd_word;
  logic        w_unused_rdata;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_xfer    = r_valid && m_ready;
  assign w_tmo_max = &r_tmo;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_WR_PTR;
      S_WR_PTR: if (w_xfer) w_next = S_WR_BD;
      S_WR_BD:  if (w_xfer) w_next = S_GAP;
      S_GAP: begin
        if (w_tmo_max) w_next = S_ERR;
        else if (r_gap == GAP_LAST) w_next = S_RD_BD;
      end
      // a finished poll with READY clear wins over the timeout
      S_RD_BD: begin
        if (w_xfer) begin
          if (!m_rdata[15]) w_next = S_DONE;
          else if (w_tmo_max) w_next = S_ERR;
          else w_next = S_GAP;
        end
      end
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // valid rises on entry to a bus state, or one cycle after WR_PTR ends
  assign w_launch = w_accept
                  || ((r_state == S_WR_BD) && !r_valid)
                  || ((r_state == S_GAP) && (w_next == S_RD_BD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
      r_gap   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ptr   <= frame_ptr;
        r_len   <= frame_len;
        r_flags <= {bd_irq, bd_wrap, bd_pad, bd_crc};
      end
      if (w_xfer) r_valid <= 1'b0;
      else if (w_launch) r_valid <= 1'b1;
      if ((r_state == S_GAP) && (w_next == S_GAP)) r_gap <= r_gap + GAP_W'(1);
      else r_gap <= '0;
      if (w_accept) r_tmo <= '0;
      else if (((r_state == S_GAP) || (r_state == S_RD_BD)) && !w_tmo_max)
        r_tmo <= r_tmo + TIMEOUT_W'(1);
    end
  end

  assign w_bd_word = {r_len, 1'b1, r_flags, 11'b0};
  assign w_wr_ptr  = r_valid && (r_state == S_WR_PTR);
  assign w_wr_bd   = r_valid && (r_state == S_WR_BD);

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);
  assign m_valid   = r_valid;
  assign m_address = !r_valid ? '0 : w_wr_ptr ? PTR_ADDR : BD_ADDR;
  assign m_wdata   = w_wr_ptr ? DATA_W'(r_ptr)
                   : w_wr_bd ? DATA_W'(w_bd_word) : '0;
  assign m_wstrb   = (w_wr_ptr || w_wr_bd) ? '1 : '0;

  assign w_unused_rdata = ^{m_rdata[DATA_W-1:16], m_rdata[14:0]};

endmodule

// File: tb/tb_iob_ethmac_tx_kick.sv
// tb_iob_ethmac_tx_kick: random frames against a transfer-list model
// with a latency-programmable IOb responder and protocol monitor.
module tb_iob_ethmac_tx_kick;

  localparam int BD  = 5;
  localparam int GAP = 16;
  localparam int TW  = 8;
  localparam int TMO_MAX = (1 << TW) - 1;
  localparam logic [9:0] A_BD  = 10'(256 + 2 * BD);
  localparam logic [9:0] A_PTR = 10'(257 + 2 * BD);

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          hold;
    int          t0;
    int          t1;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] frame_ptr = '0;
  logic [15:0] frame_len = '0;
  logic        bd_irq = 1'b0;
  logic        bd_wrap = 1'b0;
  logic        bd_pad = 1'b0;
  logic        bd_crc = 1'b0;
  logic        busy, done, err, m_valid;
  logic [9:0]  m_address;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  int lat = 0;
  int rd_busy_left = 0;
  bit rd_stuck = 1'b0;
  int cyc = 0;
  int c = 0;
  int t0 = 0;
  int n_done = 0;
  int n_err = 0;
  int n_valid = 0;
  int err_cyc = 0;
  int proto_viol = 0;
  logic p_valid = 1'b0;
  logic p_ready = 1'b0;
  logic [45:0] p_bus = '0;
  xfer_t log_q[$];
  xfer_t exp_q[$];

  iob_ethmac_tx_kick #(
    .ADDR_W(12), .DATA_W(32), .BD_IDX(BD),
    .POLL_GAP(GAP), .TIMEOUT_W(TW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_ptr(frame_ptr), .frame_len(frame_len),
    .bd_irq(bd_irq), .bd_wrap(bd_wrap),
    .bd_pad(bd_pad), .bd_crc(bd_crc),
    .busy(busy), .done(done), .err(err),
    .m_valid(m_valid), .m_address(m_address),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // responder + monitor, looking just after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      m_ready = 1'b0;
      c = 0;
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      if (p_valid && p_ready && m_valid) proto_viol++;
      if (p_valid && !p_ready && !m_valid) proto_viol++;
      if (p_valid && !p_ready && m_valid
          && {m_address, m_wdata, m_wstrb} !== p_bus) proto_viol++;
      if (done) n_done++;
      if (err) begin n_err++; err_cyc = cyc; end
      if (m_valid) n_valid++;
      m_ready = 1'b0;
      m_rdata = $urandom;
      if (m_valid) begin
        if (c == 0) t0 = cyc;
        if (c >= lat) begin
          xfer_t x;
          m_ready = 1'b1;
          m_rdata[15] = rd_stuck || (rd_busy_left > 0);
          if (m_wstrb == 4'h0 && rd_busy_left > 0) rd_busy_left--;
          x.a = m_address; x.d = m_wdata; x.s = m_wstrb;
          x.hold = c + 1; x.t0 = t0; x.t1 = cyc;
          log_q.push_back(x);
          c = 0;
        end else begin
          c++;
        end
      end else begin
        c = 0;
      end
      p_valid = m_valid;
      p_ready = m_ready;
      p_bus = {m_address, m_wdata, m_wstrb};
    end
  end

  function automatic void build_exp(input logic [31:0] p, input logic [15:0] l,
                                    input logic [3:0] f, input int polls);
    xfer_t x;
    exp_q.delete();
    x = '0;
    x.a = A_PTR; x.d = p; x.s = 4'hF;
    exp_q.push_back(x);
    x.a = A_BD;
    x.d = 32'(l) * 32'd65536 + 32'h8000 + 32'(f) * 32'd2048;
    exp_q.push_back(x);
    x.d = '0; x.s = 4'h0;
    for (int i = 0; i <= polls; i++) exp_q.push_back(x);
  endfunction

  task automatic prep(input int l, input int polls, input bit stuck);
    lat = l;
    rd_busy_left = polls;
    rd_stuck = stuck;
    log_q.delete();
    n_done = 0;
    n_err = 0;
    proto_viol = 0;
  endtask

  task automatic kick(input logic [31:0] p, input logic [15:0] l,
                      input logic [3:0] f, output logic kb, output logic kv);
    frame_ptr = p;
    frame_len = l;
    {bd_irq, bd_wrap, bd_pad, bd_crc} = f;
    start = 1'b1;
    @(posedge clk); #1;
    kb = busy;
    kv = m_valid;
    start = 1'b0;
    frame_ptr = $urandom;
    frame_len = 16'($urandom);
    {bd_irq, bd_wrap, bd_pad, bd_crc} = 4'($urandom);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, m_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/err/valid=%b want 0000",
               {busy, done, err, m_valid});
    end
    checks++;
    if ({m_address, m_wdata, m_wstrb} !== 46'h0) begin
      errors++;
      $display("FAIL reset_bus: a=%h d=%h s=%h want 0", m_address, m_wdata, m_wstrb);
    end
    rst_n = 1'b1;
    n_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || n_valid !== 0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid_cycles=%0d want 0/0", busy, n_valid);
    end
  endtask

  task automatic test_basic();
    logic kb, kv;
    bit ok;
    xfer_t got, zero;
    int g;
    zero = '0;
    prep(0, 0, 1'b0);
    build_exp(32'h8000_0000, 16'd64, 4'b1000, 0);
    kick(32'h8000_0000, 16'd64, 4'b1000, kb, kv);
    checks++;
    if ({kb, kv} !== 2'b11) begin
      errors++;
      $display("FAIL basic_start: busy/valid=%b want 11", {kb, kv});
    end
    wait_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_idle: busy=%b want 0", busy); end
    checks++;
    if (log_q.size() !== 3) begin
      errors++;
      $display("FAIL basic_count: got %0d transfers want 3", log_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < log_q.size()) ? log_q[i] : zero;
      checks++;
      if (got.a !== exp_q[i].a || got.s !== exp_q[i].s
          || (exp_q[i].s != 4'h0 && got.d !== exp_q[i].d)) begin
        errors++;
        $display("FAIL basic_xfer%0d: got a=%h d=%h s=%h want a=%h d=%h s=%h",
                 i, got.a, got.d, got.s, exp_q[i].a, exp_q[i].d, exp_q[i].s);
      end
    end
    g = (log_q.size() > 2) ? log_q[2].t0 - log_q[1].t1 - 1 : -1;
    checks++;
    if (g !== GAP) begin
      errors++;
      $display("FAIL basic_gap: got %0d idle cycles want %0d", g, GAP);
    end
    checks++;
    if (n_done !== 1 || n_err !== 0 || proto_viol !== 0) begin
      errors++;
      $display("FAIL basic_end: done=%0d err=%0d viol=%0d want 1/0/0",
               n_done, n_err, proto_viol);
    end
  endtask

  task automatic test_latency();
    logic kb, kv;
    bit ok;
    xfer_t got, zero;
    int bad, reads;
    zero = '0;
    prep(3, 2, 1'b0);
    build_exp(32'h1234_5678, 16'd1500, 4'b0101, 2);
    kick(32'h1234_5678, 16'd1500, 4'b0101, kb, kv);
    wait_idle(400, ok);
    checks++;
    if (!ok || log_q.size() !== 5) begin
      errors++;
      $display("FAIL lat_count: idle=%0d got %0d transfers want 5", ok, log_q.size());
    end
    bad = 0;
    reads = 0;
    foreach (exp_q[i]) begin
      got = (i < log_q.size()) ? log_q[i] : zero;
      if (got.s == 4'h0 && got.a == A_BD) reads++;
      if (got.a !== exp_q[i].a || got.s !== exp_q[i].s || got.hold !== 4
          || (exp_q[i].s != 4'h0 && got.d !== exp_q[i].d)) bad++;
      if (i >= 2 && i < log_q.size() && got.t0 - log_q[i-1].t1 - 1 !== GAP) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL lat_xfers: %0d bad transfer fields want 0", bad);
    end
    checks++;
    if (reads !== 3 || n_done !== 1 || n_err !== 0 || proto_viol !== 0) begin
      errors++;
      $display("FAIL lat_end: reads=%0d done=%0d err=%0d viol=%0d want 3/1/0/0",
               reads, n_done, n_err, proto_viol);
    end
  endtask

  task automatic test_ignore_start();
    logic kb, kv;
    bit ok;
    xfer_t got, zero;
    int bad;
    zero = '0;
    prep(2, 1, 1'b0);
    build_exp(32'hCAFE_0000, 16'd200, 4'b0011, 1);
    kick(32'hCAFE_0000, 16'd200, 4'b0011, kb, kv);
    for (int k = 0; k < 2; k++) begin
      repeat (k == 0 ? 2 : 10) @(posedge clk);
      #1;
      frame_ptr = 32'hDEAD_BEEF;
      frame_len = 16'd9;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle(400, ok);
    n_valid = 0;
    repeat (20) @(posedge clk);
    #1;
    bad = (log_q.size() !== exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) begin
      got = (i < log_q.size()) ? log_q[i] : zero;
      if (got.a !== exp_q[i].a || got.s !== exp_q[i].s
          || (exp_q[i].s != 4'h0 && got.d !== exp_q[i].d)) bad++;
    end
    checks++;
    if (!ok || bad !== 0) begin
      errors++;
      $display("FAIL ignore_xfers: idle=%0d bad=%0d want 1/0", ok, bad);
    end
    checks++;
    if (n_done !== 1 || n_valid !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_end: done=%0d later_valid=%0d busy=%b want 1/0/0",
               n_done, n_valid, busy);
    end
  endtask

  task automatic test_max_bd();
    logic kb, kv;
    bit ok;
    logic [31:0] w;
    prep(1, 0, 1'b0);
    kick(32'hFFFF_FFFC, 16'hFFFF, 4'hF, kb, kv);
    wait_idle(300, ok);
    w = (log_q.size() > 1) ? log_q[1].d : 32'h0;
    checks++;
    if (!ok || w !== 32'hFFFF_F800) begin
      errors++;
      $display("FAIL max_bd: idle=%0d word=%h want FFFFF800", ok, w);
    end
  endtask

  task automatic test_timeout();
    logic kb, kv;
    bit ok;
    int d, l;
    l = $urandom_range(0, 2);
    prep(l, 0, 1'b1);
    kick($urandom, 16'($urandom), 4'($urandom), kb, kv);
    wait_idle(1500, ok);
    checks++;
    if (!ok || n_err !== 1 || n_done !== 0) begin
      errors++;
      $display("FAIL tmo_pulse: idle=%0d err=%0d done=%0d want 1/1/0", ok, n_err, n_done);
    end
    d = (log_q.size() > 1) ? err_cyc - log_q[1].t1 - 1 : -1;
    checks++;
    if (d < TMO_MAX || d > TMO_MAX + 2 + l) begin
      errors++;
      $display("FAIL tmo_time: got %0d polling cycles want %0d..%0d",
               d, TMO_MAX, TMO_MAX + 2 + l);
    end
    n_valid = 0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (n_valid !== 0 || busy !== 1'b0 || proto_viol !== 0) begin
      errors++;
      $display("FAIL tmo_after: valid_cycles=%0d busy=%b viol=%0d want 0/0/0",
               n_valid, busy, proto_viol);
    end
  endtask

  task automatic test_reset_mid();
    logic kb, kv;
    bit ok, found;
    xfer_t got, zero;
    int bad;
    zero = '0;
    prep(8, 0, 1'b0);
    kick(32'h0BAD_F00D, 16'd77, 4'b1111, kb, kv);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (m_valid && m_address === A_BD) begin found = 1'b1; break; end
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!found || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: wr_bd_seen=%0d valid=%b busy=%b want 1/0/0",
               found, m_valid, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    prep(0, 1, 1'b0);
    n_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (n_valid !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_wait: valid_cycles=%0d busy=%b want 0/0", n_valid, busy);
    end
    build_exp(32'h0000_4000, 16'd60, 4'b0010, 1);
    kick(32'h0000_4000, 16'd60, 4'b0010, kb, kv);
    wait_idle(300, ok);
    bad = (log_q.size() !== exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) begin
      got = (i < log_q.size()) ? log_q[i] : zero;
      if (got.a !== exp_q[i].a || got.s !== exp_q[i].s
          || (exp_q[i].s != 4'h0 && got.d !== exp_q[i].d)) bad++;
    end
    checks++;
    if (!ok || bad !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL rstmid_rerun: idle=%0d bad=%0d done=%0d want 1/0/1",
               ok, bad, n_done);
    end
  endtask

  task automatic test_random();
    logic kb, kv;
    bit ok;
    xfer_t got, zero;
    logic [31:0] p;
    logic [15:0] l;
    logic [3:0] f;
    int bad, lt, np;
    zero = '0;
    for (int n = 0; n < 6; n++) begin
      lt = $urandom_range(0, 4);
      np = $urandom_range(0, 3);
      p = $urandom;
      l = 16'($urandom);
      f = 4'($urandom);
      prep(lt, np, 1'b0);
      build_exp(p, l, f, np);
      kick(p, l, f, kb, kv);
      wait_idle(400, ok);
      bad = (log_q.size() !== exp_q.size()) ? 1 : 0;
      foreach (exp_q[i]) begin
        got = (i < log_q.size()) ? log_q[i] : zero;
        if (got.a !== exp_q[i].a || got.s !== exp_q[i].s || got.hold !== lt + 1
            || (exp_q[i].s != 4'h0 && got.d !== exp_q[i].d)) bad++;
        if (i >= 2 && i < log_q.size() && got.t0 - log_q[i-1].t1 - 1 !== GAP) bad++;
      end
      checks++;
      if (!ok || bad !== 0 || {kb, kv} !== 2'b11) begin
        errors++;
        $display("FAIL rand%0d_xfers: idle=%0d bad=%0d start=%b want 1/0/11",
                 n, ok, bad, {kb, kv});
      end
      checks++;
      if (n_done !== 1 || n_err !== 0 || proto_viol !== 0) begin
        errors++;
        $display("FAIL rand%0d_end: done=%0d err=%0d viol=%0d want 1/0/0",
                 n, n_done, n_err, proto_viol);
      end
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_ignore_start();
    test_max_bd();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
